// File: rtl/risc_pkg.sv
// risc_pkg: opcodes, phase numbers, state encoding and strobe
// bundle shared by the accumulator CPU sequencer and ALU.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // Halted CPU reports itself as parked in the operand-address phase.
  localparam logic [2:0] PH_HALTED = PH_OP_ADDR;

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_e;

  typedef struct packed {
    logic is_hlt;
    logic is_skz;
    logic is_aluop;
    logic is_sto;
    logic is_jmp;
  } dec_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic data_e;
    logic wr;
    logic halt;
  } strb_t;

  // Reset and phase-0 strobes: only the PC drives the address mux.
  localparam strb_t STRB_RST = strb_t'(9'h100);

  // Strobes to present while sitting in state s.
  // The zero-flag term of inc_pc is added combinationally by the caller.
  function automatic strb_t strobes(state_e s, dec_t d);
    strb_t o;
    o = '0;
    case (s)
      S_INST_ADDR: begin
        o.sel = 1'b1;
      end
      S_INST_FETCH: begin
        o.sel = 1'b1;
        o.rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        o.sel   = 1'b1;
        o.rd    = 1'b1;
        o.ld_ir = 1'b1;
      end
      S_OP_ADDR: begin
        o.halt   = d.is_hlt;
        o.inc_pc = !d.is_hlt;
      end
      S_OP_FETCH: begin
        o.rd = d.is_aluop;
      end
      S_ALU_OP: begin
        o.rd     = d.is_aluop;
        o.ld_pc  = d.is_jmp;
        o.data_e = d.is_sto;
      end
      S_STORE: begin
        o.rd     = d.is_aluop;
        o.ld_ac  = d.is_aluop;
        o.ld_pc  = d.is_jmp;
        o.data_e = d.is_sto;
        o.wr     = d.is_sto;
      end
      S_HALTED: begin
        o.halt = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [2:0] phase_of(state_e s);
    return (s == S_HALTED) ? PH_HALTED : s[2:0];
  endfunction

endpackage

// File: rtl/risc_op_decode.sv
// risc_op_decode: opcode to instruction-class flags.
// Purely combinational; shared flag meanings live in risc_pkg.
module risc_op_decode
  import risc_pkg::*;
(
  input  logic [2:0] opcode_i,
  output dec_t       dec_o
);

  // Classify the opcode held in the instruction register.
  always_comb begin
    dec_o          = '0;
    dec_o.is_hlt   = (opcode_i == OP_HLT);
    dec_o.is_skz   = (opcode_i == OP_SKZ);
    dec_o.is_aluop = (opcode_i == OP_ADD) | (opcode_i == OP_AND)
                   | (opcode_i == OP_XOR) | (opcode_i == OP_LDA);
    dec_o.is_sto   = (opcode_i == OP_STO);
    dec_o.is_jmp   = (opcode_i == OP_JMP);
  end

endmodule

// File: rtl/risc_sequencer.sv
// risc_sequencer: eight-phase control FSM for the accumulator CPU.
// Define RISC_SEQ_STEP_EN to add a `run` input that gates phase 0.
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RISC_SEQ_STEP_EN
  input  logic             run,
`endif
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  strb_t            strb_q, strb_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_t             dec;
  logic             go;

`ifdef RISC_SEQ_STEP_EN
  assign go = run;
`else
  assign go = 1'b1;
`endif

  risc_op_decode u_dec (
    .opcode_i (opcode),
    .dec_o    (dec)
  );

  // Next state, next registered strobes and retire counter.
  // Strobes for phases 4-7 use the opcode sampled in the
  // preceding phase, where it is already guaranteed valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INST_ADDR: begin
        if (go) state_d = S_INST_FETCH;
      end
      S_OP_ADDR: begin
        state_d = dec.is_hlt ? S_HALTED : S_OP_FETCH;
      end
      S_STORE: begin
        state_d = S_INST_ADDR;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = state_e'(state_q + 4'd1);
      end
    endcase
    strb_d  = strobes(state_d, dec);
    phase_d = phase_of(state_d);
  end

  // State, strobe and counter registers; reset aborts any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INST_ADDR;
      strb_q  <= STRB_RST;
      phase_q <= PH_INST_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel         = strb_q.sel;
  assign rd          = strb_q.rd;
  assign ld_ir       = strb_q.ld_ir;
  assign ld_pc       = strb_q.ld_pc;
  assign ld_ac       = strb_q.ld_ac;
  assign data_e      = strb_q.data_e;
  assign wr          = strb_q.wr;
  assign halt        = strb_q.halt;
  assign phase       = phase_q;
  assign instr_count = cnt_q;

  // Skip-on-zero is the one path from the ALU flag to a strobe.
  assign inc_pc = strb_q.inc_pc
                | ((state_q == S_ALU_OP) & dec.is_skz & zero);

endmodule
